// File: rtl/vga_pkg.sv
// Shared VGA constants: pixel width, 640x480 display geometry used by both
// the timing driver and the pixel fetch stage, the eight RGB565 colour-bar
// values and the fetch FSM state type.
package vga_pkg;

  localparam int VGA_DATA_W = 16;
  localparam int VGA_H_DISP = 640;
  localparam int VGA_V_DISP = 480;
  localparam int VGA_BAR_W  = VGA_H_DISP / 8;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FILL,
    ST_DONE
  } fetch_state_t;

  // Colour of the bar containing column x; columns past the last bar are black.
  function automatic logic [15:0] bar_colour(input logic [9:0] x);
    logic [9:0] idx;
    idx = x / 10'(VGA_BAR_W);
    case (idx)
      10'd0:   bar_colour = RGB_WHITE;
      10'd1:   bar_colour = RGB_YELLOW;
      10'd2:   bar_colour = RGB_CYAN;
      10'd3:   bar_colour = RGB_GREEN;
      10'd4:   bar_colour = RGB_MAGENTA;
      10'd5:   bar_colour = RGB_RED;
      10'd6:   bar_colour = RGB_BLUE;
      default: bar_colour = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pixel_sfifo.sv
// Single-clock line FIFO for the pixel fetch stage.
// Binary pointers carry one extra wrap bit so full/empty are unambiguous.
// The read port is registered and returns zero on cycles without a pop,
// so its output can feed the display path directly.
// Ports:
//   vga_clk, sys_rst_n      clock, async active-low reset
//   clr                     synchronous flush of all contents
//   push, wdata             write side (ignored when full)
//   pop                     read side (ignored when empty)
//   rdata                   head word, valid the cycle after a pop, else 0
//   full, empty, count      occupancy status
module pixel_sfifo
  import vga_pkg::*;
#(
  parameter int DATA_W = VGA_DATA_W,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge vga_clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      rdata <= do_pop ? mem[rd_ptr[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel supply stage for the VGA timing driver. Requests RGB565 bursts from
// the frame-buffer read port into a line FIFO and answers each data_req with
// pixel_data one vga_clk later. Re-synchronises on every falling edge of
// vga_vs and keeps a sticky underflow flag for starvation.
// Optional build macro: VGA_FETCH_TESTPAT_EN adds a colour-bar generator
// selected by test_mode; without it test_mode is ignored.
// Ports:
//   vga_clk, sys_rst_n          pixel clock, async active-low reset
//   vga_vs, data_req            driver vsync (active-low) and pixel request
//   pixel_data                  pixel to the driver
//   rd_req, rd_len, rd_ack      burst request handshake
//   rd_data, rd_valid, rd_ready burst beat stream
//   frame_start                 pulse telling the frame buffer to rewind
//   underflow, underflow_clr    sticky starvation flag and its clear
//   test_mode                   colour-bar select (macro builds only)
//
// state | meaning
// IDLE  | after reset, waiting for the first frame event
// FLUSH | draining beats of any burst still in flight, then rewind
// FILL  | issuing bursts until the whole frame has been requested
// DONE  | frame fully requested, waiting for the next frame event
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int DATA_W     = VGA_DATA_W,
  parameter int FIFO_DEPTH = 1024,
  parameter int BURST_LEN  = 256,
  parameter int H_DISP     = VGA_H_DISP,
  parameter int V_DISP     = VGA_V_DISP
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              vga_vs,
  input  logic              data_req,
  output logic [DATA_W-1:0] pixel_data,
  output logic              rd_req,
  output logic [8:0]        rd_len,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic              frame_start,
  output logic              underflow,
  input  logic              underflow_clr,
  input  logic              test_mode
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);
  localparam logic [18:0]      TOTAL   = 19'(H_DISP * V_DISP);
  localparam logic [18:0]      BURST_W = 19'(BURST_LEN);

  fetch_state_t      state;
  logic              vs_q;
  logic              frame_ev;
  logic [18:0]       req_cnt;
  logic [8:0]        outstanding;
  logic [18:0]       remaining;
  logic [8:0]        len_next;

  logic              fifo_clr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  free_space;
  logic              full_next;
  logic [DATA_W-1:0] fifo_q;
  logic              beat;
  logic              streaming;

  assign frame_ev   = vs_q && !vga_vs;
  assign streaming  = (state == ST_FILL) || (state == ST_DONE);
  assign beat       = rd_valid && rd_ready;
  assign fifo_push  = beat && streaming;
  assign fifo_pop   = data_req && !fifo_empty;
  assign fifo_clr   = (state == ST_FLUSH) && (outstanding == '0);
  assign remaining  = TOTAL - req_cnt;
  assign len_next   = (remaining < BURST_W) ? remaining[8:0] : 9'(BURST_LEN);
  assign free_space = DEPTH_C - fifo_count;

  // rd_ready is registered, so it is derived from next cycle's occupancy to
  // drop in the same cycle the FIFO becomes full.
  assign count_next = fifo_clr ? '0 :
                      fifo_count + {{(CNT_W-1){1'b0}}, fifo_push}
                                 - {{(CNT_W-1){1'b0}}, fifo_pop};
  assign full_next  = (count_next == DEPTH_C);

  pixel_sfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .wdata     (rd_data),
    .pop       (fifo_pop),
    .rdata     (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      vs_q        <= 1'b0;
      rd_req      <= 1'b0;
      rd_len      <= '0;
      rd_ready    <= 1'b0;
      frame_start <= 1'b0;
      req_cnt     <= '0;
      outstanding <= '0;
    end else begin
      vs_q        <= vga_vs;
      frame_start <= 1'b0;
      if (beat && (outstanding != '0)) outstanding <= outstanding - 1'b1;

      case (state)
        ST_IDLE: begin
          rd_ready <= 1'b0;
          if (frame_ev) begin
            state    <= ST_FLUSH;
            rd_ready <= 1'b1;
          end
        end

        ST_FLUSH: begin
          rd_ready <= 1'b1;
          if (outstanding == '0) begin
            state       <= ST_FILL;
            frame_start <= 1'b1;
            req_cnt     <= '0;
            rd_ready    <= !full_next;
          end
        end

        ST_FILL, ST_DONE: begin
          if (frame_ev) begin
            // An ack racing the abort still has beats coming; flush them too.
            state    <= ST_FLUSH;
            rd_req   <= 1'b0;
            rd_ready <= 1'b1;
            if (rd_req && rd_ack) outstanding <= rd_len;
          end else begin
            rd_ready <= !full_next;
            if (state == ST_FILL) begin
              if (rd_req) begin
                if (rd_ack) begin
                  rd_req      <= 1'b0;
                  outstanding <= rd_len;
                  req_cnt     <= req_cnt + {10'd0, rd_len};
                end
              end else if (outstanding == '0) begin
                if (req_cnt < TOTAL) begin
                  if (free_space >= BURST_C) begin
                    rd_req <= 1'b1;
                    rd_len <= len_next;
                  end
                end else begin
                  state <= ST_DONE;
                end
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Set wins over a simultaneous clear so a starvation event is never lost.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underflow <= 1'b0;
    end else if (data_req && fifo_empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

`ifdef VGA_FETCH_TESTPAT_EN
  logic              req_q;
  logic [9:0]        x_cnt;
  logic [9:0]        x_now;
  logic              tp_on;
  logic [DATA_W-1:0] tp_pix;

  // The first request after a gap starts a new line at column 0.
  assign x_now = (data_req && !req_q) ? 10'd0 : x_cnt;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_q  <= 1'b0;
      x_cnt  <= '0;
      tp_on  <= 1'b0;
      tp_pix <= '0;
    end else begin
      req_q  <= data_req;
      tp_on  <= test_mode;
      tp_pix <= data_req ? DATA_W'(bar_colour(x_now)) : '0;
      if (data_req) x_cnt <= x_now + 1'b1;
    end
  end

  assign pixel_data = tp_on ? tp_pix : fifo_q;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pixel_data       = fifo_q;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 512;
  localparam int BL    = 256;
  localparam int HD    = 40;
  localparam int VD    = 20;

  logic          vga_clk;
  logic          sys_rst_n;
  logic          vga_vs;
  logic          data_req;
  logic [DW-1:0] pixel_data;
  logic          rd_req;
  logic [8:0]    rd_len;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          frame_start;
  logic          underflow;
  logic          underflow_clr;
  logic          test_mode;

  vga_pixel_fetch #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .H_DISP(HD), .V_DISP(VD)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .vga_vs(vga_vs), .data_req(data_req),
    .pixel_data(pixel_data), .rd_req(rd_req), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr),
    .test_mode(test_mode)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // frame-buffer model state
  bit            ack_en   = 1'b1;
  int            pause_at = 1 << 30;
  int            beats_left = 0;
  int            burst_beats = 0;
  int            ack_len = 0;
  int            bursts = 0;
  int            last_len = 0;
  int            acc_cnt = 0;
  int            fs_cnt = 0;
  bit            fs_pending = 1'b0;
  int            acc_at_fs = 0;
  int            beats_left_at_fs = 0;
  logic [DW-1:0] data_val = '0;
  logic [DW-1:0] frame_first = '0;

  // Frame-buffer read port: acks each request, then streams rd_len
  // incrementing words. rd_ready only changes at posedge, so a beat offered
  // at negedge with rd_ready high is the one the DUT takes next edge.
  initial begin : fb_model
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge vga_clk);
      if (!sys_rst_n) begin
        rd_ack = 1'b0; rd_valid = 1'b0; beats_left = 0;
      end else begin
        if (frame_start) begin
          fs_cnt++; fs_pending = 1'b1; acc_at_fs = acc_cnt; beats_left_at_fs = beats_left;
        end
        if (rd_ack) begin
          rd_ack = 1'b0; beats_left = ack_len; burst_beats = 0;
        end else if (ack_en && rd_req && beats_left == 0) begin
          rd_ack = 1'b1; ack_len = int'(rd_len); last_len = ack_len; bursts++;
          if (fs_pending) begin frame_first = data_val; fs_pending = 1'b0; end
        end
        rd_valid = (beats_left > 0) && (burst_beats < pause_at);
        rd_data  = data_val;
        if (rd_valid && rd_ready) begin
          data_val++; beats_left--; burst_beats++; acc_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One driver cycle: score last cycle's pixel, then drive this cycle.
  task automatic cyc(input bit req, input logic [DW-1:0] exp, input bit clr = 1'b0);
    logic [DW-1:0] e;
    @(negedge vga_clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (pixel_data === e) else begin
        errors++;
        $error("FAIL pixel_data observed %0h expected %0h", pixel_data, e);
      end
    end
    data_req = req;
    underflow_clr = clr;
    exp_q.push_back(exp);
  endtask

  logic [DW-1:0] bars [8];
  int n;
  int acc_before;
  int bursts_before;
  logic [DW-1:0] pix;

  initial begin : main
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    sys_rst_n = 1'b0; vga_vs = 1'b1; data_req = 1'b0; underflow_clr = 1'b0; test_mode = 1'b0;
    repeat (3) @(negedge vga_clk);
    chk("rst_pixel_data", 32'(pixel_data), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_len", 32'(rd_len), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_underflow", 32'(underflow), 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("idle_rd_ready", 32'(rd_ready), 0);

    // 1: first frame event; frame_start at t+2, rd_req at t+3
    vga_vs = 1'b0;
    n = 0;
    while (!rd_req && n < 20) begin
      @(negedge vga_clk); n++;
      if (n == 2) chk("frame_start_t2", 32'(frame_start), 1);
    end
    chk("rd_req_latency", 32'(n), 3);
    chk("rd_len_first", 32'(rd_len), 256);
    repeat (4) @(negedge vga_clk);
    vga_vs = 1'b1;
    chk("frame_start_once", 32'(fs_cnt), 1);

    // 2: whole (reduced) frame, driver-paced pops of 0,1,2,...
    n = 0;
    while (acc_cnt < 300 && n < 2000) begin @(negedge vga_clk); n++; end
    chk("prefill_wait", 32'(n < 2000), 1);
    pix = '0;
    for (int line = 0; line < VD; line++) begin
      for (int x = 0; x < HD; x++) begin cyc(1'b1, pix); pix++; end
      repeat (8) cyc(1'b0, '0);
    end
    repeat (5) cyc(1'b0, '0);
    chk("burst_count", 32'(bursts), 4);
    chk("last_rd_len", 32'(last_len), 32);
    chk("state_done", 32'(dut.state), 32'(ST_DONE));
    chk("no_underflow", 32'(underflow), 0);
    chk("no_rd_req_done", 32'(rd_req), 0);

    // 3: starvation
    ack_en = 1'b0;
    repeat (3) cyc(1'b1, '0);
    cyc(1'b0, '0);
    chk("underflow_set", 32'(underflow), 1);
    cyc(1'b1, '0, 1'b1);
    cyc(1'b0, '0);
    chk("underflow_set_wins", 32'(underflow), 1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0);
    chk("underflow_cleared", 32'(underflow), 0);

    // 4: abort with 100 of 256 beats delivered
    ack_en = 1'b1; pause_at = 100;
    vga_vs = 1'b0;
    repeat (3) @(negedge vga_clk);
    vga_vs = 1'b1;
    n = 0;
    while (burst_beats < 100 && n < 600) begin @(negedge vga_clk); n++; end
    chk("beats_before_abort", 32'(burst_beats), 100);
    chk("fs_before_abort", 32'(fs_cnt), 2);
    acc_before = acc_cnt;
    pause_at = 1 << 30;
    vga_vs = 1'b0;
    n = 0;
    while (fs_cnt < 3 && n < 600) begin @(negedge vga_clk); n++; end
    vga_vs = 1'b1;
    chk("abort_frame_start", 32'(fs_cnt), 3);
    chk("flush_drained", 32'(beats_left_at_fs), 0);
    chk("flush_discarded", 32'(acc_at_fs - acc_before), 156);
    n = 0;
    while (acc_cnt < acc_at_fs + 10 && n < 300) begin @(negedge vga_clk); n++; end
    cyc(1'b1, frame_first);
    repeat (2) cyc(1'b0, '0);

    // 5: back-pressure, no pops, on a fresh frame
    vga_vs = 1'b0;
    n = 0;
    while (fs_cnt < 4 && n < 600) begin @(negedge vga_clk); n++; end
    vga_vs = 1'b1;
    chk("bp_frame_start", 32'(fs_cnt), 4);
    n = 0;
    while ((rd_ready || acc_cnt == acc_at_fs) && n < 1500) begin @(negedge vga_clk); n++; end
    chk("full_rd_ready", 32'(rd_ready), 0);
    chk("full_occupancy", 32'(acc_cnt - acc_at_fs), 512);
    bursts_before = bursts;
    repeat (20) @(negedge vga_clk);
    chk("full_no_rd_req", 32'(rd_req), 0);
    chk("full_no_burst", 32'(bursts - bursts_before), 0);
    for (int k = 0; k < 255; k++) cyc(1'b1, DW'(frame_first + DW'(k)));
    repeat (6) cyc(1'b0, '0);
    chk("free255_no_rd_req", 32'(rd_req), 0);
    cyc(1'b1, DW'(frame_first + DW'(255)));
    n = 0;
    while (!rd_req && n < 6) begin cyc(1'b0, '0); n++; end
    chk("free256_rd_req", 32'(rd_req), 1);
    chk("free256_latency", 32'(n <= 3), 1);

    // reset mid-operation
    repeat (10) @(negedge vga_clk);
    sys_rst_n = 1'b0;
    @(negedge vga_clk);
    chk("midrst_rd_req", 32'(rd_req), 0);
    chk("midrst_rd_ready", 32'(rd_ready), 0);
    chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    sys_rst_n = 1'b1;
    repeat (5) @(negedge vga_clk);
    chk("postrst_rd_ready", 32'(rd_ready), 0);
    chk("postrst_count", 32'(dut.u_fifo.count), 0);

`ifdef VGA_FETCH_TESTPAT_EN
    // 6: colour bars across one line
    test_mode = 1'b1;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    for (int x = 0; x < 640; x++) cyc(1'b1, bars[x / 80]);
    cyc(1'b0, '0);
    test_mode = 1'b0;
`endif

    repeat (2) cyc(1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Pixel supply stage feeding the VGA timing driver. Requests RGB565 bursts from the frame-buffer read port and holds them in an on-chip line FIFO. Answers the driver's `data_req` with `pixel_data` exactly one `vga_clk` later. Re-synchronises to every frame on the falling edge of `vga_vs`, and flags any starvation.

## Interface

**Parameters**

- `DATA_W`, 16: pixel width (RGB565).
- `FIFO_DEPTH`, 1024: FIFO words; must be a power of two and ≥ 2×`BURST_LEN`.
- `BURST_LEN`, 256: maximum words per read burst.
- `H_DISP`, 640: active pixels per line.
- `V_DISP`, 480: active lines per frame.

**Ports**

- `vga_clk` input 1: pixel clock.
- `sys_rst_n` input 1: reset, asynchronous, active-low.
- `vga_vs` input 1: vertical sync from the driver, active-low.
- `data_req` input 1: pixel request from the driver, one cycle ahead of display.
- `pixel_data` output `DATA_W`: pixel to the driver.
- `rd_req` output 1: burst request, held until acknowledged.
- `rd_len` output 9: burst length for the current request, 1..`BURST_LEN`.
- `rd_ack` input 1: one-cycle acceptance of `rd_req`.
- `rd_data` input `DATA_W`: burst beat.
- `rd_valid` input 1: beat valid.
- `rd_ready` output 1: beat accept.
- `frame_start` output 1: one-cycle pulse; the frame-buffer controller rewinds its read address on it.
- `underflow` output 1: sticky starvation flag.
- `underflow_clr` input 1: synchronous clear of `underflow`.
- `test_mode` input 1: selects the test pattern; only has effect when `VGA_FETCH_TESTPAT_EN` is defined.

## Operation

**Frame event**
- `vga_vs` is registered once; the frame event is the cycle where the registered value is 1 and the current value is 0.

**FSM: IDLE, FLUSH, FILL, DONE**
- IDLE → FLUSH on the frame event.
- FLUSH:
  - `rd_ready`=1; arriving beats are discarded while `outstanding` counts down to 0.
  - Then: FIFO cleared, `frame_start` pulsed, `req_cnt`←0, → FILL.
  - FLUSH lasts at least one cycle.
- FILL:
  - Assert `rd_req` when all of these hold: `outstanding`==0, free space ≥ `BURST_LEN`, and `req_cnt` < `H_DISP`×`V_DISP`.
  - `rd_len` = min(`BURST_LEN`, remaining words).
  - On `rd_req`&&`rd_ack`: `outstanding`←`rd_len`, `req_cnt`+=`rd_len`, `rd_req` drops the next cycle.
  - → DONE when `req_cnt` reaches the total and `outstanding`==0.
- DONE: waits for the next frame event → FLUSH.
- A frame event in FILL or DONE → FLUSH, aborting the frame. The FIFO contents and any in-flight burst are discarded.

**Counters and widths**
- `req_cnt` is 19 bits (307200 fits).
- `outstanding` is 9 bits; it decrements on each `rd_valid`&&`rd_ready`.

**FIFO side**
- In FILL/DONE: `rd_ready` = !full. In IDLE: `rd_ready`=0.
- A push happens on `rd_valid`&&`rd_ready`.
- A push and a pop in the same cycle leave the count unchanged; a pop on full and a push on empty are both legal.

**Pop side**
- `data_req`&&!empty: pop; `pixel_data` ← head on the next cycle.
- `data_req`&&empty:
  - `pixel_data` ← 0.
  - `underflow` ← 1.
  - No pop, no pointer movement.
- `data_req`=0: `pixel_data` ← 0.

**`underflow` flag**
- Set has priority over a simultaneous `underflow_clr`.
- Not cleared by a frame event.

## Timing

- **Reset values:**
  - Outputs: `pixel_data`=0, `rd_req`=0, `rd_len`=0, `rd_ready`=0, `frame_start`=0, `underflow`=0.
  - Internal: FSM=IDLE, FIFO empty, counters 0.
- **Reset mid-operation:** immediate return to the reset state; beats arriving afterwards are ignored.
- **Pixel latency:** `data_req` high at cycle t → `pixel_data` valid at t+1. This is the driver's data_req-to-display offset.
- **Frame start:** frame event at cycle t → earliest `frame_start` at t+2 (no outstanding beats) → earliest `rd_req` at t+3.
- **Burst handshake:** `rd_req` may assert in the same cycle that `outstanding` reaches 0 plus one, i.e. at most one idle cycle between bursts.
- **FIFO timing:** all outputs are registered; the FIFO read is synchronous with a registered output.

## Configuration

- **`VGA_FETCH_TESTPAT_EN` defined:**
  - When `test_mode`=1, `pixel_data` is a colour-bar pattern from an internal x counter. The counter resets on each line's first `data_req` and increments per request.
  - Bar index is x/80: eight bars, white, yellow, cyan, green, magenta, red, blue, black, in RGB565.
  - The FIFO still pops normally, and `underflow` still tracks starvation.
- **Undefined:** the test-pattern logic is absent and `test_mode` is ignored.

## Structure

- Shared package `vga_pkg` holds:
  - the RGB565 colour constants (the eight bar colours);
  - `DATA_W`;
  - the 640×480 display constants shared with the timing driver.
- One sub-module: `pixel_sfifo`, a synchronous single-clock FIFO. It provides:
  - binary pointers with an extra wrap bit;
  - full, empty and count outputs;
  - a registered read port.
- The FSM, counters and output logic stay in `vga_pixel_fetch`.

## Test plan

1. **Reset and initial frame.** Reset, then drive `vga_vs` from 1 to 0. Required: `frame_start` pulses exactly once; `rd_req` rises with `rd_len`=256.
2. **Full frame.** Ack immediately and return incrementing data from 0; issue 307200 requests paced like the driver. Required:
   - `pixel_data` sequence 0,1,2,…, each one cycle after its `data_req`;
   - exactly 1200 bursts issued;
   - FSM ends in DONE;
   - `underflow`=0.
3. **Starvation.** Withhold `rd_ack` and issue 3 requests. Required: `pixel_data`=0 on three consecutive cycles and `underflow`=1. Then assert `underflow_clr` together with another empty request: `underflow` stays 1.
4. **Abort and resync.** Raise a frame event in the middle of a burst, with 100 of 256 beats delivered. Required:
   - the remaining 156 beats are accepted and discarded;
   - then `frame_start` pulses;
   - the first popped pixel equals the first beat of the new burst.
5. **Back-pressure.** Use `FIFO_DEPTH`=512 with no pops. Required: `rd_ready`=0 when the FIFO is full, and no further `rd_req` until free space is ≥256.
6. **Test pattern.** With `VGA_FETCH_TESTPAT_EN` defined and `test_mode`=1, request x=0, 79, 80 and 639. Required: 16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h0000.
